// File: rtl/uart_rx_framer.sv
// uart_rx_framer
//   8N1 UART receiver. Oversamples the serial line with a clock-cycle counter,
//   samples each bit at its middle, assembles bytes LSB first and hands them
//   to a consumer over a valid/ready port. Framing errors and overruns are
//   reported as single-cycle pulses.
//
// Parameters
//   clocks_per_bit  clock cycles per serial bit; must be >= 4
//
// Ports
//   clock        system clock
//   reset        asynchronous, active-high reset
//   ser_rx       serial line, idle high, asynchronous to clock
//   o_data       received byte; stable while o_valid
//   o_valid      o_data holds an unconsumed byte
//   i_ready      consumer accepts o_data when o_valid && i_ready
//   o_frame_err  1-cycle pulse: stop bit sampled low, byte discarded
//   o_overrun    1-cycle pulse: byte completed while o_valid && !i_ready
//   o_busy       high whenever the receiver is not idle
module uart_rx_framer #(
    parameter int unsigned clocks_per_bit = 80000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ser_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int unsigned CW = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(clocks_per_bit - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(clocks_per_bit / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state;
    logic            rx_m;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shift;
    logic            deliver;

    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // release never looks like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= ser_rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            deliver     <= 1'b0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            deliver     <= 1'b0;

            // Output side runs independently of the line FSM, so consumer
            // backpressure never stalls reception. A handshake in the same
            // cycle as a delivery frees the slot for the new byte.
            if (deliver) begin
                if (!o_valid || i_ready) begin
                    o_data  <= shift;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            // o_busy is assigned alongside each state transition so it
            // tracks the registered state exactly.
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CNT_MID) begin
                        if (rx_s) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state <= DATA;
                            cnt   <= '0;
                            idx   <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        shift[idx] <= rx_s;
                        cnt        <= '0;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            deliver <= 1'b1;
                            state   <= IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_HIGH: begin
                    // A held-low (break) line must not be mistaken for a
                    // stream of new start bits.
                    if (rx_s) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer
//   Self-checking bench for uart_rx_framer with clocks_per_bit = 16.
//   Bytes expected at the consumer are queued when their frame is driven and
//   compared when the consumer handshake occurs.
module tb_uart_rx_framer;

    localparam int unsigned CPB = 16;

    logic       clock;
    logic       reset;
    logic       ser_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    uart_rx_framer #(.clocks_per_bit(CPB)) dut (
        .clock       (clock),
        .reset       (reset),
        .ser_rx      (ser_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    int n_hs    = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Consumer-side monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (o_valid && i_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("sb_data", 32'(o_data), 32'(exp_q.pop_front()));
                end
            end
            if (o_frame_err) n_ferr++;
            if (o_overrun)   n_ovr++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hold(input logic level, input int cycles);
        ser_rx = level;
        repeat (cycles) tick();
    endtask

    // Drives one 8N1 frame. When stop is 0 the line is left low afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_it);
        logic [7:0] v;
        v = b;
        if (expect_it) exp_q.push_back(b);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(v[i], CPB);
        hold(stop, CPB);
        ser_rx = stop;
    endtask

    task automatic consume_one();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    int hs0, fe0, ov0;
    bit found;
    logic prev_busy;

    initial begin
        reset   = 1'b1;
        ser_rx  = 1'b1;
        i_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data",  32'(o_data),  32'd0);
        check("rst_ferr",  32'(o_frame_err), 32'd0);
        check("rst_ovr",   32'(o_overrun), 32'd0);
        check("rst_busy",  32'(o_busy),  32'd0);

        // 1: clean frame with ready high
        hs0 = n_hs; fe0 = n_ferr; ov0 = n_ovr;
        send_frame(8'h55, 1'b1, 1'b1);
        repeat (4) tick();
        check("t1_hs",    32'(n_hs - hs0), 32'd1);
        check("t1_valid", 32'(o_valid), 32'd0);
        check("t1_busy",  32'(o_busy), 32'd0);
        check("t1_flags", 32'((n_ferr - fe0) + (n_ovr - ov0)), 32'd0);

        // 2: start-bit glitch
        hs0 = n_hs; fe0 = n_ferr;
        hold(1'b0, 4);
        hold(1'b1, 30);
        check("t2_hs",   32'(n_hs - hs0), 32'd0);
        check("t2_ferr", 32'(n_ferr - fe0), 32'd0);
        check("t2_busy", 32'(o_busy), 32'd0);
        check("t2_valid", 32'(o_valid), 32'd0);

        // 3: framing error with a held-low line, then a good frame
        hs0 = n_hs; fe0 = n_ferr;
        send_frame(8'hA3, 1'b0, 1'b0);
        hold(1'b0, 40);
        check("t3_busy_low", 32'(o_busy), 32'd1);
        check("t3_ferr",     32'(n_ferr - fe0), 32'd1);
        check("t3_valid",    32'(o_valid), 32'd0);
        hold(1'b1, 6);
        check("t3_busy_idle", 32'(o_busy), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b1);
        repeat (4) tick();
        check("t3_ferr_once", 32'(n_ferr - fe0), 32'd1);
        check("t3_hs",        32'(n_hs - hs0), 32'd1);

        // 4: overrun under backpressure
        i_ready = 1'b0;
        fe0 = n_ferr; ov0 = n_ovr;
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h80, 1'b1, 1'b0);
        repeat (4) tick();
        check("t4_valid", 32'(o_valid), 32'd1);
        check("t4_data",  32'(o_data), 32'h01);
        check("t4_ovr",   32'(n_ovr - ov0), 32'd1);
        check("t4_ferr",  32'(n_ferr - fe0), 32'd0);
        consume_one();
        check("t4_valid_drop", 32'(o_valid), 32'd0);
        check("t4_data_keep",  32'(o_data), 32'h01);

        // 5: reset during data bit 4 of 0xFF
        i_ready = 1'b1;
        hold(1'b0, CPB);
        hold(1'b1, 4 * CPB + CPB / 2);
        check("t5_busy_pre", 32'(o_busy), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("t5_rst_busy",  32'(o_busy), 32'd0);
        check("t5_rst_data",  32'(o_data), 32'd0);
        check("t5_rst_valid", 32'(o_valid), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        hold(1'b1, 120);
        hs0 = n_hs;
        send_frame(8'hC3, 1'b1, 1'b1);
        repeat (4) tick();
        check("t5_hs",   32'(n_hs - hs0), 32'd1);
        check("t5_data", 32'(o_data), 32'hC3);

        // 6: ready asserted exactly in the delivery cycle of a second byte
        i_ready = 1'b0;
        ov0 = n_ovr;
        send_frame(8'h5A, 1'b1, 1'b1);
        repeat (4) tick();
        check("t6_pending", 32'(o_valid), 32'd1);
        found = 1'b0;
        fork
            send_frame(8'h11, 1'b1, 1'b1);
            begin
                prev_busy = o_busy;
                for (int i = 0; i < 400; i++) begin
                    tick();
                    if (prev_busy && !o_busy) begin
                        found = 1'b1;
                        break;
                    end
                    prev_busy = o_busy;
                end
                if (found) begin
                    // o_busy just fell at the stop sample: this is the
                    // delivery cycle.
                    i_ready = 1'b1;
                    tick();
                    i_ready = 1'b0;
                    check("t6_valid_kept", 32'(o_valid), 32'd1);
                    check("t6_data",       32'(o_data), 32'h11);
                end else begin
                    check("t6_timeout", 32'(found), 32'd1);
                end
            end
        join
        check("t6_ovr", 32'(n_ovr - ov0), 32'd0);
        consume_one();
        check("t6_valid_drop", 32'(o_valid), 32'd0);

        repeat (4) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
